// File: rtl/adder_sched.sv
// Shared-adder scheduler: round-robin arbitration of NREQ requesters onto one
// ripple-carry adder, with two-beat wide adds that lock the adder to one owner.

module thirtytwo_bit_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic c;

    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
        c   = cin;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module adder_sched #(
    parameter int NREQ = 3,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_wide,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last
);
    localparam int IW = 2;
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic         carry_q, carry_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0] rsp_sum_q, rsp_sum_d;
    logic         rsp_cout_q, rsp_cout_d;
    logic         rsp_last_q, rsp_last_d;

    logic          slot_free;
    logic          grant_any;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] idx;
    logic          accept;
    logic [W-1:0]  a_mux, b_mux;
    logic          cin_mux;
    logic [W-1:0]  add_sum;
    logic          add_cout;

    assign slot_free = !rsp_valid_q || rsp_ready;

    // Grant depends only on control state and valids, never on operands.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        if (state_q == ST_LOCK) begin
            grant_idx = owner_q;
            grant_any = req_valid[owner_q];
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = IW'((int'(ptr_q) + k) % NREQ);
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = idx;
                end
            end
        end
    end

    assign accept = grant_any && slot_free && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        a_mux   = '0;
        b_mux   = '0;
        cin_mux = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                a_mux   = req_a[i*W +: W];
                b_mux   = req_b[i*W +: W];
                cin_mux = req_cin[i];
            end
        end
        // The high beat of a wide add continues the low beat's carry.
        if (state_q == ST_LOCK) cin_mux = carry_q;
    end

    thirtytwo_bit_adder u_adder (
        .a    (a_mux),
        .b    (b_mux),
        .cin  (cin_mux),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_last_d  = rsp_last_q;

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
            rsp_last_d  = !((state_q == ST_ARB) && req_wide[grant_idx]);
            if (state_q == ST_LOCK) begin
                ptr_d   = owner_q;
                state_d = ST_ARB;
            end else if (req_wide[grant_idx]) begin
                owner_d = grant_idx;
                carry_d = add_cout;
                state_d = ST_LOCK;
            end else begin
                ptr_d = grant_idx;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_ARB;
            ptr_q       <= IW'(NREQ - 1);
            owner_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_last  = rsp_last_q;
endmodule

// File: tb/tb_adder_sched.sv
// Directed-vector bench for adder_sched: reset, single add, round-robin,
// wide add with lock, backpressure and reset during a lock.

module tb_adder_sched;
    localparam int NREQ = 3;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_wide;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_last;

    int n_vec = 0;
    int n_err = 0;

    adder_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_wide  (req_wide),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic wide);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_wide[i]     = wide;
    endtask

    // Advance one edge and settle registered outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [W-1:0] sum,
                             input logic cout, input logic last);
        check({tag, ".valid"}, 64'(rsp_valid), 64'(1'b1));
        check({tag, ".id"},    64'(rsp_id),    64'(id));
        check({tag, ".sum"},   64'(rsp_sum),   64'(sum));
        check({tag, ".cout"},  64'(rsp_cout),  64'(cout));
        check({tag, ".last"},  64'(rsp_last),  64'(last));
    endtask

    logic [W-1:0] rr_sum [NREQ];

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_wide  = '0;

        // Reset held 3 cycles with all requesters valid.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.req_ready", 64'(req_ready), 64'(3'b000));
            check("rst.rsp_valid", 64'(rsp_valid), 64'(1'b0));
        end
        check("rst.rsp_sum",  64'(rsp_sum),  64'(0));
        check("rst.rsp_id",   64'(rsp_id),   64'(0));
        check("rst.rsp_cout", 64'(rsp_cout), 64'(0));
        check("rst.rsp_last", 64'(rsp_last), 64'(0));

        // Round-robin: all three valid, no bubbles.
        set_req(0, 32'd10,        32'd20, 1'b0, 1'b0);
        set_req(1, 32'h0000_1000, 32'd1,  1'b1, 1'b0);
        set_req(2, 32'd5,         32'd7,  1'b0, 1'b0);
        rr_sum[0] = 32'd30;
        rr_sum[1] = 32'h0000_1002;
        rr_sum[2] = 32'd12;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr.grant%0d", i), 64'(req_ready), 64'(3'b001 << (i % 3)));
            tick();
            check_rsp($sformatf("rr.rsp%0d", i), 2'(i % 3), rr_sum[i % 3], 1'b0, 1'b1);
        end
        req_valid = '0;
        tick();
        check("rr.drain", 64'(rsp_valid), 64'(1'b0));

        // Single add from requester 1 wraps to zero with carry out.
        req_valid = 3'b010;
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        #1;
        check("single.grant", 64'(req_ready), 64'(3'b010));
        tick();
        check_rsp("single", 2'd1, 32'h0000_0000, 1'b1, 1'b1);
        req_valid = '0;
        tick();

        // Wide add from requester 2 while requester 0 stays valid.
        req_valid = 3'b101;
        set_req(0, 32'd3, 32'd4, 1'b1, 1'b0);
        set_req(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        #1;
        check("wide.lo_grant", 64'(req_ready), 64'(3'b100));
        tick();
        check_rsp("wide.lo", 2'd2, 32'h0000_0000, 1'b1, 1'b0);
        // Owner stalls: lock holds and requester 0 is still refused.
        req_valid = 3'b001;
        #1;
        check("wide.lock_hold", 64'(req_ready), 64'(3'b000));
        tick();
        check("wide.lock_idle", 64'(rsp_valid), 64'(1'b0));
        // High beat: req_cin and req_wide must be ignored, carry comes from the low beat.
        req_valid = 3'b101;
        set_req(2, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1);
        #1;
        check("wide.hi_grant", 64'(req_ready), 64'(3'b100));
        tick();
        check_rsp("wide.hi", 2'd2, 32'h0000_0004, 1'b0, 1'b1);
        req_valid = 3'b001;
        #1;
        check("wide.after", 64'(req_ready), 64'(3'b001));

        // Backpressure: held result must stay put and no new grant.
        rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp.ready%0d", i), 64'(req_ready), 64'(3'b000));
            tick();
            check_rsp($sformatf("bp.hold%0d", i), 2'd2, 32'h0000_0004, 1'b0, 1'b1);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release", 64'(req_ready), 64'(3'b001));
        tick();
        check_rsp("bp.new", 2'd0, 32'd8, 1'b0, 1'b1);
        req_valid = '0;
        tick();

        // Reset while requester 1 holds a lock.
        req_valid = 3'b010;
        set_req(1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        #1;
        check("rlock.lo_grant", 64'(req_ready), 64'(3'b010));
        tick();
        check_rsp("rlock.lo", 2'd1, 32'h0000_0001, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rlock.rst_ready", 64'(req_ready), 64'(3'b000));
        tick();
        check("rlock.rst_valid", 64'(rsp_valid), 64'(1'b0));
        rst = 1'b0;
        // Back in ARB with ptr reset: requester 0 wins before requester 1.
        req_valid = 3'b011;
        set_req(1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        #1;
        check("rlock.arb_grant", 64'(req_ready), 64'(3'b001));
        tick();
        check_rsp("rlock.r0", 2'd0, 32'd8, 1'b0, 1'b1);
        check("rlock.r1_grant", 64'(req_ready), 64'(3'b010));
        tick();
        check_rsp("rlock.single", 2'd1, 32'h0000_0030, 1'b0, 1'b1);
        check("rlock.still_arb", 64'(req_ready), 64'(3'b001));
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adder_sched.md
# adder_sched

Shared-adder scheduler for the MIPS datapath. It arbitrates up to three requesters (PC increment, branch-target, ALU add/sub) onto one instance of the team's 32-bit ripple-carry adder `thirtytwo_bit_adder`. Arbitration is round-robin, and results are registered behind a valid/ready output. Two-beat "wide" requests chain the carry for 64-bit adds, locking the adder to one owner across both beats.

## Interface
- `NREQ`, 3, number of requesters (fixed at 3 for this revision; `rsp_id` is 2 bits)
- `W`, 32, operand width (must match the adder instance)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NREQ: per-requester request valid
- `req_ready` out NREQ: per-requester grant; a beat is accepted when `req_valid[i] & req_ready[i]`
- `req_a` in NREQ*W: operand A; requester i occupies bits [i*W +: W]
- `req_b` in NREQ*W: operand B, packed the same way
- `req_cin` in NREQ: carry-in for single and low beats
- `req_wide` in NREQ: on a beat accepted in ARB, marks the low half of a 64-bit add
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: consumer accepts result
- `rsp_id` out 2: index of the requester that owns the result
- `rsp_sum` out W: sum modulo 2^W
- `rsp_cout` out 1: carry out of bit W-1
- `rsp_last` out 1: 1 for a single beat or a high beat; 0 for a low beat

## Operation
- **Adder input mux.** One adder instance. Its inputs are muxed from the granted requester. Its cin is `req_cin[g]` in ARB and `carry_q` in LOCK.
- **Output slot.** The slot is free when `!rsp_valid | rsp_ready`. All `req_ready` are 0 while the slot is not free. At most one `req_ready` bit is high in any cycle.
- **FSM: ARB.**
  - Grant goes to the first `req_valid` requester, searching from `ptr+1` mod NREQ upward.
  - On acceptance with `req_wide=0`: set `ptr` to g and stay in ARB.
  - On acceptance with `req_wide=1`: set `owner` to g, set `carry_q` to the adder cout, go to LOCK. `ptr` is not updated.
- **FSM: LOCK.**
  - Only `req_ready[owner]` may be high, and only when the slot is free. Other requesters wait.
  - The owner's next accepted beat is the high beat: cin is `carry_q`, and `req_cin`/`req_wide` are ignored.
  - On high-beat acceptance: set `ptr` to `owner`, go to ARB.
  - If the owner deasserts valid, LOCK holds indefinitely. Requesters must present the high beat promptly.
- **Result register.** Loaded on every acceptance with {id, sum, cout, last}. `rsp_last` is 0 for a low beat and 1 otherwise.
- **Backpressure.** While `rsp_valid & !rsp_ready`, all `rsp_*` outputs hold stable.
- **Reset.**
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `rsp_last`=0.
  - State=ARB, `ptr`=NREQ-1 so requester 0 has first priority; `carry_q`=0, `owner`=0.
  - `req_ready`=0 in any cycle where `rst`=1.
  - Reset during LOCK discards the lock and `carry_q`. The owner must resend both beats.

## Timing
- **Grant path.** `req_ready` is combinational from state, `ptr`, `owner`, `req_valid`, `rsp_valid` and `rsp_ready`. It never depends on `req_a`/`req_b`.
- **Latency.** 1 cycle: a beat accepted at edge N gives `rsp_valid`=1 with its data after edge N.
- **Throughput.** One beat per cycle while `rsp_ready`=1. The consumer may accept a result and a new beat may be accepted in the same cycle.
- **Wide op.** The low and high beats occupy two accepted cycles, back-to-back at best. No other requester's result appears between them.
- **Simultaneous requests.** In ARB, requesters are served in strict rotation. With all three valid continuously, grants go 0,1,2,0,…
- **Critical path.** The ripple adder plus the input mux ends at the result register. There is no combinational path from `req_a`/`req_b` to any output.

## Test plan
- **Reset.** Hold `rst` 3 cycles with all `req_valid`=1. Expect `req_ready`=0 and `rsp_valid`=0. On the first cycle after reset, expect the grant to go to requester 0.
- **Single add.** Req1 sends a=0xFFFF_FFFF, b=0x0000_0001, cin=0. One cycle later expect `rsp_sum`=0x0000_0000, `rsp_cout`=1, `rsp_id`=1, `rsp_last`=1.
- **Round-robin.** Hold all three valid with `rsp_ready`=1. Expect grants 0,1,2,0,1,2. Expect `rsp_id` to follow one cycle later, with no bubbles.
- **Wide add.** Req2 sends a low beat (a=0xFFFF_FFFF, b=1, cin=0, wide=1) while req0 is continuously valid. Req2 then sends a high beat (a=0x0000_0001, b=0x0000_0002).
  - Expect results {sum=0, cout=1, last=0}, then {sum=0x0000_0004, cout=0, last=1}, both with id 2.
  - Expect req0 not granted until the high beat is accepted.
- **Backpressure.** `rsp_ready`=0 for 4 cycles with req0 valid. Expect `rsp_*` stable and `req_ready`=0 throughout. When `rsp_ready` rises, expect the held result to drain and req0 to be accepted in the same cycle.
- **Reset mid-LOCK.** Pulse `rst` after req1's low beat is accepted. Expect state ARB, `rsp_valid`=0, and a beat from req1 with wide=0 treated as a single add using `req_cin`.
